// File: rtl/i2c_pkg.sv
// Shared I2C constants: default FIFO depth and TX/RX entry widths.
package i2c_pkg;

    localparam int I2C_FIFO_DEPTH = 16;
    localparam int I2C_TXD_W      = 10;
    localparam int I2C_RXD_W      = 8;

endpackage

// File: rtl/i2c_fifo.sv
// i2c_fifo: show-ahead FIFO with sticky overflow/underflow flags and synchronous flush.
// Threshold interrupt is built only when I2C_FIFO_THRESH_IRQ_EN is defined.
//
// Handshake: a write is taken on any cycle with wr=1 unless full (a
// simultaneous rd frees the slot); a pop is taken on any cycle with rd=1
// while not empty; dout always shows the head entry.
module i2c_fifo
    import i2c_pkg::*;
#(
    parameter int  DATA_W = I2C_TXD_W,
    parameter int  DEPTH  = I2C_FIFO_DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       ocy,
    input  logic [AW:0]       pirq,
    output logic              irq_thr,
    output logic              ovf,
    output logic              unf,
    input  logic              err_clr
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [AW:0]       wptr_nxt;
    logic [AW:0]       rptr_nxt;
    logic              wr_ok;
    logic              rd_ok;
    logic              ovf_set;
    logic              unf_set;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign ocy   = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

    assign wr_ok   = wr && (!full || rd);
    assign rd_ok   = rd && !empty;
    assign ovf_set = wr && full && !rd;
    assign unf_set = rd && empty;

    always_comb begin
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        if (flush) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
        end else begin
            if (wr_ok) wptr_nxt = wptr + PTR_ONE;
            if (rd_ok) rptr_nxt = rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr_nxt;
            rptr <= rptr_nxt;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) mem[wptr[AW-1:0]] <= din;
    end

    // A new error event outranks err_clr in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= ovf_set || (ovf && !err_clr);
            unf <= unf_set || (unf && !err_clr);
        end
    end

`ifdef I2C_FIFO_THRESH_IRQ_EN
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [AW:0] ocy_nxt;
    logic        irq_q;

    // Registered from next-state occupancy so it lines up with the new ocy.
    assign ocy_nxt = wptr_nxt - rptr_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (pirq < DEPTH_C) && (ocy_nxt > pirq);
        end
    end

    assign irq_thr = irq_q;
`else
    logic unused_pirq;

    assign unused_pirq = ^pirq;
    assign irq_thr     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_fifo.sv
// Self-checking bench for i2c_fifo: vector table, directed corner sequences,
// random traffic against a queue model, and a DEPTH=4 wrap run.
module tb_i2c_fifo;

    localparam int DW    = 10;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int D4    = 4;

`ifdef I2C_FIFO_THRESH_IRQ_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    // clock / reset
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          flush, wr, rd, err_clr;
    logic [DW-1:0] din, dout;
    logic          full, empty, irq_thr, ovf, unf;
    logic [AW:0]   ocy, pirq;

    logic          wr4, rd4;
    logic [DW-1:0] din4, dout4;
    logic          full4, empty4, irq4, ovf4, unf4;
    logic [2:0]    ocy4;
    logic          flush4   = 1'b0;
    logic          err_clr4 = 1'b0;
    logic [2:0]    pirq4    = 3'd2;

    i2c_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rstn(rstn), .flush(flush), .wr(wr), .din(din), .rd(rd),
        .dout(dout), .full(full), .empty(empty), .ocy(ocy), .pirq(pirq),
        .irq_thr(irq_thr), .ovf(ovf), .unf(unf), .err_clr(err_clr)
    );

    i2c_fifo #(.DATA_W(DW), .DEPTH(D4)) u_dut4 (
        .clk(clk), .rstn(rstn), .flush(flush4), .wr(wr4), .din(din4), .rd(rd4),
        .dout(dout4), .full(full4), .empty(empty4), .ocy(ocy4), .pirq(pirq4),
        .irq_thr(irq4), .ovf(ovf4), .unf(unf4), .err_clr(err_clr4)
    );

    // scoreboard
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp4_q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    int            n_cmp = 0;
    int            n_err = 0;

    typedef struct {
        bit            w;
        bit            r;
        bit            ec;
        logic [DW-1:0] d;
        logic [AW:0]   e_ocy;
        bit            e_ovf;
        bit            e_unf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        bit exp_irq;
        n       = exp_q.size();
        exp_irq = THR_EN && (int'(pirq) < DEPTH) && (n > int'(pirq));
        chk({tag, ".ocy"},   32'(ocy),     32'(n));
        chk({tag, ".full"},  32'(full),    32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(empty),   32'(n == 0));
        chk({tag, ".ovf"},   32'(ovf),     32'(m_ovf));
        chk({tag, ".unf"},   32'(unf),     32'(m_unf));
        chk({tag, ".irq"},   32'(irq_thr), 32'(exp_irq));
    endtask

    // driver: one clock of stimulus on the DEPTH=16 instance
    task automatic do_cycle(input bit w, input logic [DW-1:0] d, input bit r,
                            input bit f, input bit ec, input string tag);
        int            n;
        logic [DW-1:0] e;
        @(negedge clk);
        wr = w; din = d; rd = r; flush = f; err_clr = ec;
        #1;
        n = exp_q.size();
        if (r && n > 0 && !f) begin
            e = exp_q.pop_front();
            chk({tag, ".dout"}, 32'(dout), 32'(e));
        end
        if (f) exp_q.delete();
        else if (w && (n < DEPTH || r)) exp_q.push_back(d);
        m_ovf = (w && n == DEPTH && !r) || (m_ovf && !ec);
        m_unf = (r && n == 0) || (m_unf && !ec);
        @(posedge clk);
        #1;
        check_state(tag);
        wr = 0; rd = 0; flush = 0; err_clr = 0;
    endtask

    // driver: one clock of stimulus on the DEPTH=4 instance
    task automatic cycle4(input bit w, input logic [DW-1:0] d, input bit r);
        int            n;
        logic [DW-1:0] e;
        @(negedge clk);
        wr4 = w; din4 = d; rd4 = r;
        #1;
        n = exp4_q.size();
        if (r && n > 0) begin
            e = exp4_q.pop_front();
            chk("wrap.dout", 32'(dout4), 32'(e));
        end
        if (w && (n < D4 || r)) exp4_q.push_back(d);
        @(posedge clk);
        #1;
        n = exp4_q.size();
        chk("wrap.ocy",   32'(ocy4),   32'(n));
        chk("wrap.full",  32'(full4),  32'(n == D4));
        chk("wrap.empty", 32'(empty4), 32'(n == 0));
        wr4 = 0; rd4 = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;

        vecs[0] = '{w:0, r:1, ec:0, d:'h000, e_ocy:0, e_ovf:0, e_unf:1};
        vecs[1] = '{w:0, r:0, ec:1, d:'h000, e_ocy:0, e_ovf:0, e_unf:0};
        vecs[2] = '{w:0, r:1, ec:1, d:'h000, e_ocy:0, e_ovf:0, e_unf:1};
        vecs[3] = '{w:1, r:0, ec:0, d:'h155, e_ocy:1, e_ovf:0, e_unf:1};
        vecs[4] = '{w:1, r:1, ec:0, d:'h0AA, e_ocy:1, e_ovf:0, e_unf:1};
        vecs[5] = '{w:0, r:0, ec:1, d:'h000, e_ocy:1, e_ovf:0, e_unf:0};
        vecs[6] = '{w:0, r:1, ec:0, d:'h000, e_ocy:0, e_ovf:0, e_unf:0};
        vecs[7] = '{w:1, r:1, ec:0, d:'h033, e_ocy:1, e_ovf:0, e_unf:1};
        vecs[8] = '{w:0, r:1, ec:0, d:'h000, e_ocy:0, e_ovf:0, e_unf:1};
        vecs[9] = '{w:0, r:0, ec:1, d:'h000, e_ocy:0, e_ovf:0, e_unf:0};

        flush = 0; wr = 0; rd = 0; err_clr = 0; din = '0; pirq = 5'd5;
        wr4 = 0; rd4 = 0; din4 = '0;

        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_cycle(vecs[i].w, vecs[i].d, vecs[i].r, 1'b0, vecs[i].ec, "vec");
            chk($sformatf("vec%0d.ocy", i), 32'(ocy), 32'(vecs[i].e_ocy));
            chk($sformatf("vec%0d.ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d.unf", i), 32'(unf), 32'(vecs[i].e_unf));
        end

        // fill and drain in order
        for (int i = 0; i < 16; i++) do_cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, "fill");
        chk("fill.full_const", 32'(full), 32'd1);
        chk("fill.ocy_const",  32'(ocy),  32'd16);
        for (int i = 0; i < 16; i++) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "drain");
        chk("drain.empty_const", 32'(empty), 32'd1);

        // overflow while full, then write+read while full
        for (int i = 0; i < 16; i++)
            do_cycle(1'b1, DW'($urandom_range(0, 1023)), 1'b0, 1'b0, 1'b0, "refill");
        do_cycle(1'b1, 'h3FF, 1'b0, 1'b0, 1'b0, "ovf");
        chk("ovf.set",  32'(ovf), 32'd1);
        chk("ovf.ocy",  32'(ocy), 32'd16);
        do_cycle(1'b1, 'h2AA, 1'b1, 1'b0, 1'b0, "ovf_wr_rd");
        chk("ovf_wr_rd.ocy", 32'(ocy), 32'd16);
        chk("ovf_wr_rd.ovf", 32'(ovf), 32'd1);
        for (int i = 0; i < 16; i++) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "ovf_drain");
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, "ovf_clr");
        chk("ovf_clr.ovf", 32'(ovf), 32'd0);

        // threshold
        pirq = 5'd3;
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, DW'(16'h100 + i), 1'b0, 1'b0, 1'b0, "thr");
            if (i == 2) chk("thr.below", 32'(irq_thr), 32'd0);
        end
        chk("thr.at4", 32'(irq_thr), 32'(THR_EN));
        do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "thr_rd");
        chk("thr_rd.irq", 32'(irq_thr), 32'd0);
        pirq = 5'd16;
        for (int i = 0; i < 14; i++) do_cycle(1'b1, DW'(i + 7), 1'b0, 1'b0, 1'b0, "thr16");
        chk("thr16.full_irq", 32'(irq_thr), 32'd0);
        pirq = 5'd5;

        // flush priority with ocy=5
        do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, "flush0");
        for (int i = 0; i < 5; i++) do_cycle(1'b1, DW'(16'h0C0 + i), 1'b0, 1'b0, 1'b0, "pre_flush");
        chk("pre_flush.ocy", 32'(ocy), 32'd5);
        do_cycle(1'b1, 'h111, 1'b1, 1'b1, 1'b0, "flush");
        chk("flush.ocy",   32'(ocy),   32'd0);
        chk("flush.empty", 32'(empty), 32'd1);

        // reset in the middle of traffic
        do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "pre_rst_unf");
        for (int i = 0; i < 3; i++) do_cycle(1'b1, DW'(16'h070 + i), 1'b0, 1'b0, 1'b0, "pre_rst");
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_state("rst_mid");
        @(negedge clk);
        rstn = 1'b1;
        do_cycle(1'b1, 'h123, 1'b0, 1'b0, 1'b0, "post_rst");
        chk("post_rst.dout", 32'(dout), 32'h123);
        do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "post_rst_rd");

        // random traffic
        for (int i = 0; i < 300; i++) begin
            do_cycle(1'($urandom_range(0, 1)), DW'($urandom_range(0, 1023)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 9) == 0), "rand");
        end

        // DEPTH=4 wrap: prefill 3, then alternating write/read pairs
        v = 'h200;
        for (int i = 0; i < 3; i++) begin
            cycle4(1'b1, v, 1'b0);
            v = v + 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            cycle4(1'b1, v, 1'b0);
            v = v + 1'b1;
            cycle4(1'b0, '0, 1'b1);
        end
        for (int i = 0; i < 3; i++) cycle4(1'b0, '0, 1'b1);
        chk("wrap.final_empty", 32'(empty4), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_fifo.md
I2C_FIFO -- requirements
Module: i2c_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 10, entry width in bits (8 data + 2 control for TX use).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; a power of two and at least 2.
REQ-003 SHALL have local constant AW = log2(DEPTH); occupancy width is AW+1.
REQ-004 SHALL have ports as follows; one clock, reset asynchronous active-low:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents.
- wr  in  1  write strobe.
- din  in  DATA_W  write data.
- rd  in  1  read/pop strobe.
- dout  out  DATA_W  head entry.
- full  out  1  occupancy equals DEPTH.
- empty  out  1  occupancy equals 0.
- ocy  out  AW+1  current occupancy.
- pirq  in  AW+1  threshold.
- irq_thr  out  1  threshold interrupt.
- ovf  out  1  sticky overflow.
- unf  out  1  sticky underflow.
- err_clr  in  1  clears ovf/unf.

Function
REQ-005 SHALL store entries in a DEPTH x DATA_W register array, using AW+1-bit read/write pointers that wrap modulo 2*DEPTH.
REQ-006 SHALL define full when pointer MSBs differ and the low AW bits are equal; empty when the pointers are equal; ocy = wptr - rptr, modulo 2^(AW+1).
REQ-007 SHALL be show-ahead: dout = mem[rptr] combinationally; dout is don't-care while empty.
REQ-008 SHALL accept wr when not full: mem[wptr] <= din and wptr increments at the next edge.
REQ-009 SHALL drop wr when full unless rd is also asserted that cycle, and set ovf on a dropped write.
REQ-010 SHALL pop on rd when not empty (rptr increments); rd while empty SHALL be ignored and SHALL set unf.
REQ-011 SHALL handle simultaneous wr and rd as follows:
- Non-empty: both accepted, ocy unchanged, including when full.
- Empty: write accepted, read ignored, unf set.
REQ-012 SHALL clear both pointers on flush at the next edge, with priority over wr/rd in the same cycle; ovf/unf are unaffected.
REQ-013 SHALL clear ovf and unf on err_clr; a new error event in the same cycle SHALL win, leaving the flag set.
REQ-014 SHALL implement irq_thr as a register updated every cycle with (next ocy > pirq), so it is valid in the same cycle as the new ocy.
REQ-015 SHALL force irq_thr to 0 when pirq >= DEPTH (threshold unreachable).

Reset
REQ-016 SHALL on rstn low, asynchronously:
- Set pointers to 0, ocy=0, empty=1, full=0.
- Set ovf=0, unf=0, irq_thr=0.
- Leave array contents unreset.
REQ-017 SHALL treat reset asserted mid-operation as discarding all entries; the first accepted write after release appears on dout the next cycle.

Configuration
REQ-018 SHALL compile the threshold interrupt (REQ-014, REQ-015) only when I2C_FIFO_THRESH_IRQ_EN is defined.
REQ-019 SHALL, without I2C_FIFO_THRESH_IRQ_EN, tie irq_thr to 0, ignore pirq, and instantiate no threshold register.

Structure
REQ-020 SHALL take the default depth and width constants (I2C_FIFO_DEPTH=16, I2C_TXD_W=10, I2C_RXD_W=8) from the shared package i2c_pkg.
REQ-021 SHALL be a single module with no sub-modules; the storage array is inline.

Verification
REQ-022 SHALL cover fill-and-drain: 16 writes of 0x000..0x00F, then 16 reads.
- After the writes: full=1, ocy=16.
- Reads return dout 0x000..0x00F in order, then empty=1.
REQ-023 SHALL cover overflow: when full, wr 0x3FF alone sets ovf=1 with ocy=16 and contents unchanged.
- A subsequent wr with rd set keeps ocy=16 and ovf unchanged.
REQ-024 SHALL cover underflow and clear: rd on empty sets unf=1.
- err_clr then clears it; err_clr together with rd on empty keeps unf=1.
REQ-025 SHALL cover the threshold with pirq=3 and the macro defined:
- 4th write gives irq_thr=1 in the same cycle ocy=4.
- One read gives irq_thr=0.
- pirq=16 gives irq_thr=0 always.
REQ-026 SHALL cover flush priority: with ocy=5, flush+wr+rd in the same cycle gives ocy=0 and empty=1.
REQ-027 SHALL cover wrap: 40 alternating write/read pairs with a DEPTH=4 build.
- dout matches the write order throughout.
- Pointers wrap with no spurious full or empty.
